// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and constants for the instruction memory loader
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CHK,
      S_DONE
   } state_t;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs big-endian bytes into 32-bit words
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        word_valid_o,
   output logic [31:0] word_data_o
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   // Only the first three bytes are held; the fourth is merged on the fly
   // so the complete word is available in the cycle of its last transfer.
   logic [1:0]  idx_q, idx_d;
   logic [23:0] shift_q, shift_d;

   // Advance byte index and shift in each accepted byte
   always_comb begin
      idx_d   = idx_q;
      shift_d = shift_q;
      if (byte_valid_i) begin
         idx_d   = idx_q + 2'd1;
         shift_d = {shift_q[15:0], byte_data_i};
      end
   end

   // Byte index and shift register storage
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   assign word_valid_o = byte_valid_i && (idx_q == LAST_IDX);
   assign word_data_o  = {shift_q, byte_data_i};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader for instruction memory (option: IMEM_LOADER_CHKSUM_EN)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHKSUM_EN
   localparam state_t S_END = S_CHK;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic              im_we_q, im_we_d;
   logic [ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [31:0]       im_wdata_q, im_wdata_d;
   logic              done_q, done_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              err_q, err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   logic        xfer;
   logic        word_valid;
   logic [31:0] word_data;

   assign rx_ready = (state_q != S_DONE);
   assign xfer     = rx_valid && rx_ready;

   imem_loader_word_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .byte_valid_i (xfer && (state_q == S_DATA)),
      .byte_data_i  (rx_data),
      .word_valid_o (word_valid),
      .word_data_o  (word_data)
   );

   // Header parsing, word write scheduling and completion sequencing
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      word_cnt_d = word_cnt_q;
      im_we_d    = 1'b0;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      err_d      = err_q;
      case (state_q)
         S_HDR0: begin
            if (xfer) begin
               n_d     = CNT_W'({rx_data, 8'h00});
               state_d = S_HDR1;
            end
         end
         S_HDR1: begin
            if (xfer) begin
               n_d = n_q | CNT_W'(rx_data);
               if (32'(n_d) > DEPTH) begin
                  err_d = 1'b1;
               end
               state_d = (n_d == '0) ? S_END : S_DATA;
            end
         end
         S_DATA: begin
            if (word_valid) begin
               // Words past the top of memory are consumed but never written,
               // so an oversized image cannot wrap onto the low addresses.
               im_we_d    = ((word_cnt_q >> ADDR_W) == '0);
               im_addr_d  = word_cnt_q[ADDR_W-1:0];
               im_wdata_d = word_data;
               word_cnt_d = word_cnt_q + CNT_W'(1);
               if (word_cnt_d == n_q) begin
                  state_d = S_END;
               end
            end
         end
`ifdef IMEM_LOADER_CHKSUM_EN
         S_CHK: begin
            if (xfer) begin
               if (rx_data != sum_q) begin
                  err_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_HDR0;
         end
      endcase
      // done waits out a final write strobe so the CPU is released only
      // after the last word has landed in memory.
      done_d    = (state_d == S_DONE) && !im_we_d;
      cpu_rst_d = !done_d;
   end

`ifdef IMEM_LOADER_CHKSUM_EN
   // Running mod-256 sum of header and data bytes
   always_comb begin
      sum_d = sum_q;
      if (xfer && (state_q != S_CHK)) begin
         sum_d = sum_q + rx_data;
      end
   end

   // Checksum accumulator storage
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   // Loader state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_HDR0;
         n_q        <= '0;
         word_cnt_q <= '0;
         im_we_q    <= 1'b0;
         im_addr_q  <= '0;
         im_wdata_q <= '0;
         done_q     <= 1'b0;
         cpu_rst_q  <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         word_cnt_q <= word_cnt_d;
         im_we_q    <= im_we_d;
         im_addr_q  <= im_addr_d;
         im_wdata_q <= im_wdata_d;
         done_q     <= done_d;
         cpu_rst_q  <= cpu_rst_d;
         err_q      <= err_d;
      end
   end

   assign im_we    = im_we_q;
   assign im_addr  = im_addr_q;
   assign im_wdata = im_wdata_q;
   assign done     = done_q;
   assign cpu_rst  = cpu_rst_q;
   assign err      = err_q;
   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a 4-word memory
module tb_imem_loader;

   localparam int ADDR_W = 2;
   localparam int CNT_W  = 16;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;
   logic [CNT_W-1:0]  word_cnt;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int                cyc;
   } exp_t;

   exp_t        sb[$];
   int          tests  = 0;
   int          failed = 0;
   int          cyc    = 0;
   int          gap_g  = 0;
   logic [7:0]  sum_g;
   logic [31:0] img [8];
   logic [31:0] big [8];

   imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (!rst && im_we) begin
         if (sb.size() == 0) begin
            chk("unexpected_we", 32'(im_we), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("we_addr", 32'(im_addr), 32'(e.addr));
            chk("we_data", im_wdata, e.data);
            chk("we_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Called just after a negedge; returns at the negedge after the transfer
   task automatic send_b(input logic [7:0] b, input bit push, input int idx, input logic [31:0] w);
      int k;
      exp_t e;
      rx_data  = b;
      rx_valid = 1'b1;
      k = 0;
      while (!rx_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!rx_ready) begin
         chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
         rx_valid = 1'b0;
         return;
      end
      if (push) begin
         e.addr = idx[ADDR_W-1:0];
         e.data = w;
         e.cyc  = cyc + 1;
         sb.push_back(e);
      end
      sum_g = sum_g + b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap_g) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int idx);
      send_b(w[31:24], 1'b0, idx, w);
      send_b(w[23:16], 1'b0, idx, w);
      send_b(w[15:8],  1'b0, idx, w);
      send_b(w[7:0],   idx < DEPTH, idx, w);
   endtask

   task automatic load(input int n, input logic [31:0] w [8], input bit bad_sum, input bit exp_ovf);
      logic [15:0] nn;
      nn    = 16'(n);
      sum_g = 8'h00;
      send_b(nn[15:8], 1'b0, 0, 32'h0);
      send_b(nn[7:0],  1'b0, 0, 32'h0);
      chk("hdr_err", 32'(err), 32'(exp_ovf));
      for (int i = 0; i < n; i++) send_word(w[i], i);
`ifdef IMEM_LOADER_CHKSUM_EN
      send_b(bad_sum ? sum_g + 8'h01 : sum_g, 1'b0, 0, 32'h0);
`endif
   endtask

   task automatic end_chk(input int exp_cnt, input bit exp_err);
      @(negedge clk);
      chk("done", 32'(done), 32'd1);
      chk("cpu_rst", 32'(cpu_rst), 32'd0);
      chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
      chk("err", 32'(err), 32'(exp_err));
      chk("rx_ready_done", 32'(rx_ready), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      img = '{32'h3C011234, 32'h34215678, 0, 0, 0, 0, 0, 0};
      big = '{32'h11223344, 32'hA5A5F00F, 32'hDEADBEEF, 32'h01020304, 32'hCAFEBABE, 0, 0, 0};
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("rst_im_we", 32'(im_we), 32'd0);
      chk("rst_im_addr", 32'(im_addr), 32'd0);
      chk("rst_im_wdata", im_wdata, 32'd0);
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      rst = 1'b0;

      // Two-word image, back-to-back bytes
      load(2, img, 1'b0, 1'b0);
`ifndef IMEM_LOADER_CHKSUM_EN
      chk("done_lag", 32'(done), 32'd0);
      chk("cpu_rst_lag", 32'(cpu_rst), 32'd1);
`endif
      end_chk(2, 1'b0);

      // Empty image; extra valid bytes after completion are ignored
      do_rst();
      load(0, img, 1'b0, 1'b0);
`ifndef IMEM_LOADER_CHKSUM_EN
      chk("n0_done_now", 32'(done), 32'd1);
      chk("n0_rx_ready", 32'(rx_ready), 32'd0);
`endif
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      end_chk(0, 1'b0);

      // Same image with a one-cycle gap after every byte
      do_rst();
      gap_g = 1;
      load(2, img, 1'b0, 1'b0);
      end_chk(2, 1'b0);
      gap_g = 0;

      // Oversized image: five words into four-word memory
      do_rst();
      load(5, big, 1'b0, 1'b1);
      end_chk(5, 1'b1);

      // Exactly full memory is not an overflow
      do_rst();
      load(4, big, 1'b0, 1'b0);
      end_chk(4, 1'b0);

      // Reset after six bytes, then a clean reload
      do_rst();
      send_b(8'h00, 1'b0, 0, 32'h0);
      send_b(8'h02, 1'b0, 0, 32'h0);
      send_word(32'h3C011234, 0);
      do_rst();
      chk("abort_word_cnt", 32'(word_cnt), 32'd0);
      load(2, img, 1'b0, 1'b0);
      end_chk(2, 1'b0);

`ifdef IMEM_LOADER_CHKSUM_EN
      // Wrong trailer still releases the CPU but flags an error
      do_rst();
      load(2, img, 1'b1, 1'b0);
      end_chk(2, 1'b1);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
